// File: rtl/mantissa_divider_seq.sv
// Iterative restoring divider for hidden-bit significands: retires BITS_PER_CYCLE
// quotient bits per cycle and returns truncated quotient, exact remainder, sticky and norm.
module mantissa_divider_seq #(
  parameter int MANT_WIDTH     = 23,
  parameter int GUARD_BITS     = 2,
  parameter int BITS_PER_CYCLE = 1,
  localparam int W      = MANT_WIDTH + 1,
  localparam int Q_FRAC = MANT_WIDTH + GUARD_BITS,
  localparam int N      = Q_FRAC + 1,
  localparam int ITER   = N / BITS_PER_CYCLE,
  localparam int CW     = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_WIDTH-1:0] in_mant_a,
  input  logic [MANT_WIDTH-1:0] in_mant_b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_quotient,
  output logic [W-1:0]          out_remainder,
  output logic                  out_sticky,
  output logic                  out_norm,
  output logic [1:0]            dbg_state
);

  if (N % BITS_PER_CYCLE != 0) begin : g_bad_radix
    $error("quotient width must be a multiple of BITS_PER_CYCLE");
  end
  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    r_q, r_d;     // partial remainder, MSB doubles as sign of R-B
  logic [W-1:0]  b_q, b_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;

  logic [W:0]    r_t;
  logic [W:0]    diff;
  logic [N-1:0]  q_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // flush overrides any transfer on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    b_d       = b_q;
    q_d       = q_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    r_t       = r_q;
    q_t       = q_q;
    diff      = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          b_d     = {1'b1, in_mant_b};
          r_d     = {2'b01, in_mant_a};
          q_d     = '0;
          cnt_d   = CW'(ITER - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
          diff = r_t - {1'b0, b_q};
          if (!diff[W]) r_t = diff;
          q_t = {q_t[N-2:0], ~diff[W]};
          // The very last quotient bit leaves R unshifted so it is the true remainder.
          if (!((cnt_q == '0) && (j == BITS_PER_CYCLE - 1))) r_t = r_t << 1;
        end
        r_d = r_t;
        q_d = q_t;
        if (cnt_q == '0) begin
          quo_d   = q_t;
          rem_d   = r_t[W-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      b_q     <= b_d;
      q_q     <= q_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign out_quotient  = quo_q;
  assign out_remainder = rem_q;
  assign out_sticky    = |rem_q;
  assign out_norm      = quo_q[N-1];
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Bench for mantissa_divider_seq: radix-1 and radix-2 instances run side by side against
// an integer floor/mod reference, plus latency, backpressure, flush and reset scenarios.
module tb_mantissa_divider_seq;

  localparam int MW = 23;
  localparam int W  = MW + 1;
  localparam int N  = MW + 2 + 1;
  localparam int N_RAND = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [MW-1:0] in_mant_a = '0;
  logic [MW-1:0] in_mant_b = '0;
  logic          in_valid  [2];
  logic          out_ready [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic [N-1:0]  out_quo   [2];
  logic [W-1:0]  out_rem   [2];
  logic          out_sticky[2];
  logic          out_norm  [2];
  logic [1:0]    dbg_state [2];

  int errors = 0;
  int checks = 0;
  int exp_lat [2] = '{26, 13};
  logic [N+2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mantissa_divider_seq #(.MANT_WIDTH(MW), .GUARD_BITS(2), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mant_a(in_mant_a), .in_mant_b(in_mant_b), .flush(flush),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_quotient(out_quo[0]),
    .out_remainder(out_rem[0]), .out_sticky(out_sticky[0]), .out_norm(out_norm[0]),
    .dbg_state(dbg_state[0]));

  mantissa_divider_seq #(.MANT_WIDTH(MW), .GUARD_BITS(2), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mant_a(in_mant_a), .in_mant_b(in_mant_b), .flush(flush),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_quotient(out_quo[1]),
    .out_remainder(out_rem[1]), .out_sticky(out_sticky[1]), .out_norm(out_norm[1]),
    .dbg_state(dbg_state[1]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer floor/mod of A*2^25 by B with the hidden bits restored.
  task automatic push_expected(input logic [MW-1:0] a, input logic [MW-1:0] b);
    longint unsigned big_a, big_b, num;
    logic [N-1:0] q;
    logic [W-1:0] r;
    big_a = (64'd1 << MW) + 64'(a);
    big_b = (64'd1 << MW) + 64'(b);
    num   = big_a << 25;
    q     = N'(num / big_b);
    r     = W'(num % big_b);
    exp_q.push_back({q, r, W'(big_b)});
  endtask

  task automatic start_op(input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    check("in_ready_before_start0", 64'(in_ready[0]), 64'd1);
    check("in_ready_before_start1", 64'(in_ready[1]), 64'd1);
    in_mant_a = a;
    in_mant_b = b;
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    push_expected(a, b);
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge; that negedge is cycle 0.
  task automatic wait_done();
    int lat [2];
    lat = '{-1, -1};
    for (int e = 0; e < 40; e++) begin
      for (int i = 0; i < 2; i++)
        if (out_valid[i] && lat[i] < 0) lat[i] = e;
      if (lat[0] >= 0 && lat[1] >= 0) break;
      @(negedge clk);
    end
    check("latency_bpc1", 64'(lat[0]), 64'(exp_lat[0]));
    check("latency_bpc2", 64'(lat[1]), 64'(exp_lat[1]));
  endtask

  task automatic check_res(input bit pop);
    logic [N-1:0] eq;
    logic [W-1:0] er, eb;
    {eq, er, eb} = exp_q[0];
    if (pop) void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'd1);
      check($sformatf("in_ready_busy%0d", i), 64'(in_ready[i]), 64'd0);
      check($sformatf("quotient%0d", i), 64'(out_quo[i]), 64'(eq));
      check($sformatf("remainder%0d", i), 64'(out_rem[i]), 64'(er));
      check($sformatf("sticky%0d", i), 64'(out_sticky[i]), 64'(er != 0));
      check($sformatf("norm%0d", i), 64'(out_norm[i]), 64'(eq[N-1]));
      check($sformatf("rem_lt_b%0d", i), 64'(out_rem[i] < eb), 64'd1);
    end
  endtask

  task automatic release_out();
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid_after_release%0d", i), 64'(out_valid[i]), 64'd0);
      check($sformatf("in_ready_after_release%0d", i), 64'(in_ready[i]), 64'd1);
    end
  endtask

  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b);
    start_op(a, b);
    wait_done();
    check_res(1'b1);
    release_out();
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid[0] || out_valid[1]) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [MW-1:0] ra, rb;
    in_valid  = '{1'b0, 1'b0};
    out_ready = '{1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
      check($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
      check($sformatf("rst_quotient%0d", i), 64'(out_quo[i]), 64'd0);
      check($sformatf("rst_remainder%0d", i), 64'(out_rem[i]), 64'd0);
      check($sformatf("rst_sticky%0d", i), 64'(out_sticky[i]), 64'd0);
      check($sformatf("rst_norm%0d", i), 64'(out_norm[i]), 64'd0);
    end

    // Directed corner operands, including literal anchors for the key results
    start_op(23'h0, 23'h0);
    wait_done();
    check("one_over_one_quo", 64'(out_quo[0]), 64'h2000000);
    check_res(1'b1);
    release_out();
    start_op(23'h0, 23'h400000);
    wait_done();
    check("one_over_1p5_quo", 64'(out_quo[1]), 64'h1555555);
    check("one_over_1p5_rem", 64'(out_rem[0]), 64'h400000);
    check_res(1'b1);
    release_out();
    start_op(23'h7FFFFF, 23'h0);
    wait_done();
    check("max_over_one_quo", 64'(out_quo[1]), 64'h3FFFFFC);
    check_res(1'b1);
    release_out();
    run_op(23'h0, 23'h7FFFFF);
    run_op(23'h7FFFFF, 23'h7FFFFF);
    run_op(23'h7FFFFE, 23'h7FFFFF);

    // Backpressure: DONE holds with in_valid pulsing, then the waiting operand goes in
    start_op(23'h123456, 23'h654321);
    wait_done();
    check_res(1'b1);
    in_mant_a = 23'h0;
    in_mant_b = 23'h0;
    in_valid  = '{1'b1, 1'b1};
    push_expected(23'h0, 23'h0);
    exp_q.push_front(exp_q[0]);
    {exp_q[0][N+2*W-1:0]} = exp_q[0];
    void'(exp_q.pop_front());
    push_expected(23'h123456, 23'h654321);
    exp_q.push_front(exp_q[exp_q.size()-1]);
    void'(exp_q.pop_back());
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_res(1'b0);
    end
    void'(exp_q.pop_front());
    out_ready = '{1'b1, 1'b1};
    @(negedge clk);
    out_ready = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_in_ready_after_release%0d", i), 64'(in_ready[i]), 64'd1);
      check($sformatf("bp_out_valid_after_release%0d", i), 64'(out_valid[i]), 64'd0);
    end
    @(negedge clk);
    in_valid = '{1'b0, 1'b0};
    wait_done();
    check_res(1'b1);
    release_out();

    // Flush during BUSY: result never appears
    start_op(23'h2AAAAA, 23'h155555);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready0", 64'(in_ready[0]), 64'd1);
    check("flush_in_ready1", 64'(in_ready[1]), 64'd1);
    expect_quiet("flush_no_out_valid", 40);

    // Flush coincident with in_valid in IDLE: nothing starts
    @(negedge clk);
    in_valid = '{1'b1, 1'b1};
    flush = 1'b1;
    @(negedge clk);
    in_valid = '{1'b0, 1'b0};
    flush = 1'b0;
    check("idle_flush_in_ready0", 64'(in_ready[0]), 64'd1);
    check("idle_flush_in_ready1", 64'(in_ready[1]), 64'd1);
    expect_quiet("idle_flush_no_start", 35);

    // Asynchronous reset mid-operation
    start_op(23'h333333, 23'h0F0F0F);
    void'(exp_q.pop_back());
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
      check($sformatf("async_rst_quotient%0d", i), 64'(out_quo[i]), 64'd0);
      check($sformatf("async_rst_remainder%0d", i), 64'(out_rem[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("reset_no_out_valid", 40);
    run_op(23'h0, 23'h0);

    // Random operand pairs against the integer reference
    for (int k = 0; k < N_RAND; k++) begin
      ra = MW'($urandom);
      rb = MW'($urandom);
      if ($urandom_range(0, 15) == 0) ra = 23'h7FFFFF;
      if ($urandom_range(0, 15) == 0) rb = 23'h0;
      run_op(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
